hilo_issue: RTL and testbench

Issue and hazard controller directly upstream of the `mod_mult` HI/LO multiply-divide unit. It decodes EX-stage HI/LO instructions (MULT, DIV, MULTU, DIVU, MTHI, MTLO, MFHI, MFLO) and drives registered operands, `start`, `mult_ctr` and `mult_write` into the unit. It stalls the pipeline while the unit is occupied and returns MFHI/MFLO data only once HI/LO are settled. It also covers the unit's one-cycle `mult_busy` gap after `start`.

---
 rtl/hilo_pkg.sv | 48 ++++
 rtl/hilo_issue.sv | 147 ++++++++++++++
 tb/tb_hilo_issue.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO issue controller.
// HILO_STALL_CNT_EN in hilo_issue adds a stall-cycle counter output.
package hilo_pkg;

   typedef enum logic [3:0] {
      HILO_NONE  = 4'd0,
      HILO_MULT  = 4'd1,
      HILO_DIV   = 4'd2,
      HILO_MULTU = 4'd3,
      HILO_DIVU  = 4'd4,
      HILO_MTHI  = 4'd5,
      HILO_MTLO  = 4'd6,
      HILO_MFHI  = 4'd7,
      HILO_MFLO  = 4'd8
   } hilo_op_t;

   localparam logic [2:0] CTR_MULT  = 3'd0;
   localparam logic [2:0] CTR_DIV   = 3'd1;
   localparam logic [2:0] CTR_MULTU = 3'd2;
   localparam logic [2:0] CTR_DIVU  = 3'd3;

   localparam logic [1:0] WR_NONE = 2'd0;
   localparam logic [1:0] WR_HI   = 2'd1;
   localparam logic [1:0] WR_LO   = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_ARM   = 3'd2,
      ST_BUSY  = 3'd3,
      ST_WRITE = 3'd4
   } hilo_state_t;

   function automatic logic is_md_op(input hilo_op_t op);
      return (op == HILO_MULT) || (op == HILO_DIV) ||
             (op == HILO_MULTU) || (op == HILO_DIVU);
   endfunction

   function automatic logic [2:0] op_to_ctr(input hilo_op_t op);
      case (op)
         HILO_DIV:   return CTR_DIV;
         HILO_MULTU: return CTR_MULTU;
         HILO_DIVU:  return CTR_DIVU;
         default:    return CTR_MULT;
      endcase
   endfunction

endpackage

// File: rtl/hilo_issue.sv
// Issue/hazard controller in front of the mod_mult HI/LO unit.
// Optional feature: define HILO_STALL_CNT_EN to add the stall_cnt output.
module hilo_issue
   import hilo_pkg::*;
#(
   parameter int ARM_WAIT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  hilo_op_t    ex_op,
   input  logic [31:0] ex_rs,
   input  logic [31:0] ex_rt,
   input  logic        flush,
   input  logic        mult_busy,
   input  logic [31:0] HI,
   input  logic [31:0] LO,
   output logic [31:0] C,
   output logic [31:0] D,
   output logic [2:0]  mult_ctr,
   output logic [1:0]  mult_write,
   output logic        start,
   output logic        stall,
   output logic [31:0] hilo_rdata
`ifdef HILO_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam int CW = (ARM_WAIT > 1) ? $clog2(ARM_WAIT) : 1;
   localparam logic [CW-1:0] ARM_LAST = CW'(ARM_WAIT - 1);

   hilo_state_t   r_state;
   hilo_state_t   w_next;
   logic [31:0]   r_c;
   logic [31:0]   r_d;
   logic [2:0]    r_ctr;
   logic [1:0]    r_wsel;
   logic [CW-1:0] r_arm_cnt;

   logic w_req;
   logic w_accept;
   logic w_md;
   logic w_mt;

   // The unit itself is never reset, so mult_busy gates acceptance even in IDLE.
   assign w_req    = ex_valid & ~flush & (ex_op != HILO_NONE);
   assign w_accept = w_req & (r_state == ST_IDLE) & ~mult_busy;
   assign w_md     = w_accept & is_md_op(ex_op);
   assign w_mt     = w_accept & ((ex_op == HILO_MTHI) || (ex_op == HILO_MTLO));
   assign stall    = w_req & ~w_accept;

   assign C        = r_c;
   assign D        = r_d;
   assign mult_ctr = r_ctr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      start      = 1'b0;
      mult_write = WR_NONE;
      hilo_rdata = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_md) begin
               w_next = ST_ISSUE;
            end else if (w_mt) begin
               w_next = ST_WRITE;
            end
         end
         ST_ISSUE: begin
            start  = 1'b1;
            w_next = ST_ARM;
         end
         ST_ARM: begin
            // Busy rises a cycle after start; give up if it never does.
            if (mult_busy) begin
               w_next = ST_BUSY;
            end else if (r_arm_cnt == ARM_LAST) begin
               w_next = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!mult_busy) begin
               w_next = ST_IDLE;
            end
         end
         ST_WRITE: begin
            mult_write = r_wsel;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      if (w_accept && (ex_op == HILO_MFHI)) begin
         hilo_rdata = HI;
      end else if (w_accept && (ex_op == HILO_MFLO)) begin
         hilo_rdata = LO;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c       <= '0;
         r_d       <= '0;
         r_ctr     <= CTR_MULT;
         r_wsel    <= WR_NONE;
         r_arm_cnt <= '0;
      end else begin
         if (w_md) begin
            r_c   <= ex_rs;
            r_d   <= ex_rt;
            r_ctr <= op_to_ctr(ex_op);
         end else if (w_mt) begin
            r_c    <= ex_rs;
            r_wsel <= (ex_op == HILO_MTHI) ? WR_HI : WR_LO;
         end
         if (r_state != ST_ARM) begin
            r_arm_cnt <= '0;
         end else if (!mult_busy) begin
            r_arm_cnt <= r_arm_cnt + CW'(1);
         end
      end
   end

`ifdef HILO_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (stall) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hilo_issue.sv
// Self-checking bench for hilo_issue with a behavioural mod_mult stand-in.
// Build with HILO_STALL_CNT_EN defined to also check stall_cnt.
module tb_hilo_issue;
   import hilo_pkg::*;

   localparam int ARM_WAIT = 2;
   localparam int MAXWAIT  = 60;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   hilo_op_t    ex_op = HILO_NONE;
   logic [31:0] ex_rs = '0;
   logic [31:0] ex_rt = '0;
   logic        flush = 1'b0;
   logic        mult_busy = 1'b0;
   logic [31:0] HI = '0;
   logic [31:0] LO = '0;
   logic [31:0] C, D, hilo_rdata;
   logic [2:0]  mult_ctr;
   logic [1:0]  mult_write;
   logic        start, stall;
`ifdef HILO_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   hilo_issue #(.ARM_WAIT(ARM_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .mult_busy(mult_busy),
      .HI(HI), .LO(LO), .C(C), .D(D), .mult_ctr(mult_ctr),
      .mult_write(mult_write), .start(start), .stall(stall),
      .hilo_rdata(hilo_rdata)
`ifdef HILO_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] refHi = '0;
   logic [31:0] refLo = '0;
   int          expStarts = 0, startPulses = 0;
   int          expWrHi = 0, expWrLo = 0, wrHi = 0, wrLo = 0;
   logic [31:0] tbStallCnt = '0;
   bit          dropStart = 1'b0;
   int          fixedLat = 3;

   // Architectural multiply/divide result as {HI, LO}.
   function automatic logic [63:0] mdCalc(input bit isDiv, input bit isSigned,
                                          input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      int                 sa, sb;
      if (!isDiv) begin
         if (isSigned) begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            return sp;
         end
         up = {32'd0, a} * {32'd0, b};
         return up;
      end
      if (b == 32'd0) return 64'd0;
      if (isSigned) begin
         sa = $signed(a);
         sb = $signed(b);
         return {32'(sa % sb), 32'(sa / sb)};
      end
      return {a % b, a / b};
   endfunction

   // Behavioural unit: busy rises one cycle after start is seen, results land when it falls.
   logic        pend = 1'b0;
   logic [63:0] pendRes = '0;
   int          busyLeft = 0;
   always @(posedge clk) begin
      if (mult_write == WR_HI) HI <= C;
      else if (mult_write == WR_LO) LO <= C;
      if (pend) begin
         pend      <= 1'b0;
         mult_busy <= 1'b1;
         busyLeft  <= (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
      end else if (mult_busy) begin
         if (busyLeft <= 1) begin
            mult_busy <= 1'b0;
            HI        <= pendRes[63:32];
            LO        <= pendRes[31:0];
         end else begin
            busyLeft <= busyLeft - 1;
         end
      end
      if (start && !dropStart) begin
         pend    <= 1'b1;
         pendRes <= mdCalc(mult_ctr[0], ~mult_ctr[1], C, D);
      end
   end

   always @(posedge clk) begin
      if (start) startPulses++;
      if (mult_write == WR_HI) wrHi++;
      if (mult_write == WR_LO) wrLo++;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) tbStallCnt = '0;
      else if (stall) tbStallCnt = tbStallCnt + 32'd1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present one EX instruction, hold it while stalled, check its result, update the program-order model.
   task automatic applyStimulus(input hilo_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                                output int stallCycles, output logic [31:0] rdata);
      logic [63:0] res;
      ex_valid = 1'b1;
      ex_op    = op;
      ex_rs    = rs;
      ex_rt    = rt;
      stallCycles = 0;
      @(negedge clk);
      while (stall && stallCycles < MAXWAIT) begin
         stallCycles++;
         @(negedge clk);
      end
      checkOutput("stall_bound", 32'(stall), 32'd0);
      rdata = hilo_rdata;
      case (op)
         HILO_MFHI: checkOutput("mfhi_data", hilo_rdata, refHi);
         HILO_MFLO: checkOutput("mflo_data", hilo_rdata, refLo);
         default:   checkOutput("rdata_zero", hilo_rdata, 32'd0);
      endcase
      case (op)
         HILO_MULT, HILO_DIV, HILO_MULTU, HILO_DIVU: begin
            expStarts++;
            if (!dropStart) begin
               res = mdCalc((op == HILO_DIV) || (op == HILO_DIVU),
                            (op == HILO_MULT) || (op == HILO_DIV), rs, rt);
               refHi = res[63:32];
               refLo = res[31:0];
            end
         end
         HILO_MTHI: begin refHi = rs; expWrHi++; end
         HILO_MTLO: begin refLo = rs; expWrLo++; end
         default: ;
      endcase
      @(posedge clk); #1;
      ex_valid = 1'b0;
      ex_op    = HILO_NONE;
   endtask

   initial begin
      int          sc;
      logic [31:0] rd, a, b, mtv;
      hilo_op_t    op;

      // Reset values
      @(negedge clk);
      checkOutput("rst_C", C, 32'd0);
      checkOutput("rst_D", D, 32'd0);
      checkOutput("rst_ctr", 32'(mult_ctr), 32'd0);
      checkOutput("rst_write", 32'(mult_write), 32'd0);
      checkOutput("rst_start", 32'(start), 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_rdata", hilo_rdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Signed MULT -2 * 3
      fixedLat = 3;
      applyStimulus(HILO_MULT, 32'hFFFF_FFFE, 32'd3, sc, rd);
      @(negedge clk);
      checkOutput("mult_start", 32'(start), 32'd1);
      checkOutput("mult_C", C, 32'hFFFF_FFFE);
      checkOutput("mult_D", D, 32'd3);
      checkOutput("mult_ctr", 32'(mult_ctr), 32'd0);
      @(posedge clk); #1;
      applyStimulus(HILO_MFLO, 32'd0, 32'd0, sc, rd);
      checkOutput("mflo_stalled", 32'(sc > 0), 32'd1);
      checkOutput("mflo_value", rd, 32'hFFFF_FFFA);
      applyStimulus(HILO_MFHI, 32'd0, 32'd0, sc, rd);
      checkOutput("mfhi_nostall", 32'(sc), 32'd0);
      checkOutput("mfhi_value", rd, 32'hFFFF_FFFF);

      // DIVU 100/7 back-to-back with MULTU 5*6: ISSUE + ARM + busy + final BUSY cycle
      applyStimulus(HILO_DIVU, 32'd100, 32'd7, sc, rd);
      applyStimulus(HILO_MULTU, 32'd5, 32'd6, sc, rd);
      checkOutput("multu_stall_len", 32'(sc), 32'(fixedLat + 3));
      checkOutput("divu_hi", HI, 32'd2);
      checkOutput("divu_lo", LO, 32'd14);
      applyStimulus(HILO_MFHI, 32'd0, 32'd0, sc, rd);
      checkOutput("multu_hi", rd, 32'd0);
      applyStimulus(HILO_MFLO, 32'd0, 32'd0, sc, rd);
      checkOutput("multu_lo", rd, 32'd30);

      // MTHI then MFHI next cycle, same for MTLO
      applyStimulus(HILO_MTHI, 32'h1234_5678, 32'd0, sc, rd);
      applyStimulus(HILO_MFHI, 32'd0, 32'd0, sc, rd);
      checkOutput("mthi_mf_stall", 32'(sc), 32'd1);
      checkOutput("mthi_value", rd, 32'h1234_5678);
      mtv = $urandom;
      applyStimulus(HILO_MTLO, mtv, 32'd0, sc, rd);
      applyStimulus(HILO_MFLO, 32'd0, 32'd0, sc, rd);
      checkOutput("mtlo_mf_stall", 32'(sc), 32'd1);
      checkOutput("mtlo_value", rd, mtv);

      // Flush a MULT stalled behind a busy DIV
      fixedLat = 5;
      applyStimulus(HILO_DIV, 32'hFFFF_FF9C, 32'd7, sc, rd);
      ex_valid = 1'b1; ex_op = HILO_MULT; ex_rs = 32'd9; ex_rt = 32'd9;
      @(negedge clk);
      checkOutput("pre_flush_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      checkOutput("flush_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      // Flush beats an otherwise acceptable MF
      ex_op = HILO_MFHI;
      @(negedge clk);
      checkOutput("flush_mf_stall", 32'(stall), 32'd0);
      checkOutput("flush_mf_rdata", hilo_rdata, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; ex_valid = 1'b0; ex_op = HILO_NONE;
      applyStimulus(HILO_MFLO, 32'd0, 32'd0, sc, rd);
      checkOutput("div_signed_lo", rd, 32'hFFFF_FFF2);

      // Reset while the unit is busy
      fixedLat = 8;
      applyStimulus(HILO_DIV, 32'd1000, 32'd7, sc, rd);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_C", C, 32'd0);
      checkOutput("midrst_D", D, 32'd0);
      checkOutput("midrst_ctr", 32'(mult_ctr), 32'd0);
      checkOutput("midrst_start", 32'(start), 32'd0);
      checkOutput("midrst_write", 32'(mult_write), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      fixedLat = 3;
      applyStimulus(HILO_MULT, 32'h8000_0001, 32'h0000_0010, sc, rd);
      checkOutput("postrst_stalled", 32'(sc > 0), 32'd1);
      applyStimulus(HILO_MFHI, 32'd0, 32'd0, sc, rd);
      applyStimulus(HILO_MFLO, 32'd0, 32'd0, sc, rd);

      // Lost start: FSM gives up after ARM_WAIT cycles, HI/LO untouched
      dropStart = 1'b1;
      applyStimulus(HILO_MULT, 32'd77, 32'd88, sc, rd);
      applyStimulus(HILO_MFHI, 32'd0, 32'd0, sc, rd);
      dropStart = 1'b0;
      checkOutput("lost_start_stall", 32'(sc), 32'(ARM_WAIT + 1));

      // Randomized instruction stream against the program-order model
      fixedLat = 0;
      for (int i = 0; i < 60; i++) begin
         op = hilo_op_t'(4'($urandom_range(0, 8)));
         a  = $urandom;
         b  = $urandom;
         if ((op == HILO_DIV) || (op == HILO_DIVU)) begin
            b = 32'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            if (a == 32'h8000_0000) a = 32'd1;
         end
         applyStimulus(op, a, b, sc, rd);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (20) @(posedge clk);
      #1;
      checkOutput("start_pulses", 32'(startPulses), 32'(expStarts));
      checkOutput("write_hi_pulses", 32'(wrHi), 32'(expWrHi));
      checkOutput("write_lo_pulses", 32'(wrLo), 32'(expWrLo));
`ifdef HILO_STALL_CNT_EN
      checkOutput("stall_cnt", stall_cnt, tbStallCnt);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
